// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_pkg : shared encodings and defaults for the program-counter stage        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pc_pkg;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_next_mux : next-PC selector with misalignment detection                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(PC_TRAP_VECTOR)
) (
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] pcplus4,
  input  logic [XLEN-1:0] pc_target,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] w_sel;

  // Reserved encoding 11 falls back to sequential flow.
  always_comb begin
    w_sel = pcplus4;
    case (pc_src)
      PCSRC_TARGET: w_sel = pc_target;
      PCSRC_JALR:   w_sel = alu_result & ~XLEN'(1);
      default:      w_sel = pcplus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misaligned = |w_sel[1:0];
  assign next_pc    = misaligned ? TRAP_VECTOR : w_sel;
`else
  assign misaligned = 1'b0;
  assign next_pc    = w_sel & ~XLEN'(3);
`endif

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer : PC register, BOOT/RUN/HALT sequencing and retire counter     |
// | Optional misaligned-target trap enabled by macro PC_MISALIGN_TRAP_EN        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            halt_req,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            pc_valid,
  output logic            halted,
  output logic [31:0]     instret,
  output logic            misalign
);

  pc_state_t       r_state;
  pc_state_t       w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [31:0]     r_instret;
  logic            r_misalign;
  logic            w_mux_misaligned;
  logic            w_advance;
  logic            w_retire;

  assign PCPlus4 = r_pc + XLEN'(4);

  pc_next_mux #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_mux (
    .pc_src     (PCSrc),
    .pcplus4    (PCPlus4),
    .pc_target  (PCTarget),
    .alu_result (ALUResult),
    .next_pc    (w_next_pc),
    .misaligned (w_mux_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_next;
  end

  // A halting instruction still retires but does not move the PC.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (en) begin
          w_retire = 1'b1;
          if (halt_req) w_state_next = HALT;
          else          w_advance    = 1'b1;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_instret  <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_advance & w_mux_misaligned;
      if (w_advance) r_pc      <= w_next_pc;
      if (w_retire)  r_instret <= r_instret + 32'd1;
    end
  end

  assign PC       = r_pc;
  assign instret  = r_instret;
  assign misalign = r_misalign;
  assign pc_valid = (r_state == RUN);
  assign halted   = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer : directed + random bench against a behavioural PC model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] C_TRAP_VECTOR  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] PCTarget = 32'h0;
  logic [31:0] ALUResult = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        pc_valid;
  logic        halted;
  logic [31:0] instret;
  logic        misalign;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc   = C_RESET_VECTOR;
  logic [31:0] m_cnt  = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  bit          m_mis  = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .PCSrc     (PCSrc),
    .PCTarget  (PCTarget),
    .ALUResult (ALUResult),
    .halt_req  (halt_req),
    .PC        (PC),
    .PCPlus4   (PCPlus4),
    .pc_valid  (pc_valid),
    .halted    (halted),
    .instret   (instret),
    .misalign  (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    logic [31:0] sel;
    if (rst) begin
      m_pc = C_RESET_VECTOR; m_cnt = 0; m_boot = 1; m_halt = 0; m_mis = 0;
    end else if (m_boot) begin
      m_boot = 0; m_mis = 0;
    end else if (m_halt || !en) begin
      m_mis = 0;
    end else begin
      m_cnt = m_cnt + 1;
      m_mis = 0;
      if (halt_req) m_halt = 1;
      else begin
        if (PCSrc == 2'b01)      sel = PCTarget;
        else if (PCSrc == 2'b10) sel = {ALUResult[31:1], 1'b0};
        else                     sel = m_pc + 4;
`ifdef PC_MISALIGN_TRAP_EN
        if (sel % 4 != 0) begin m_pc = C_TRAP_VECTOR; m_mis = 1; end
        else m_pc = sel;
`else
        m_pc = sel - (sel % 4);
`endif
      end
    end
  endtask

  task automatic check_all();
    check("pc",       PC,              m_pc);
    check("pcplus4",  PCPlus4,         m_pc + 32'd4);
    check("pc_valid", 32'(pc_valid),   32'(!m_boot && !m_halt));
    check("halted",   32'(halted),     32'(m_halt));
    check("instret",  instret,         m_cnt);
    check("misalign", 32'(misalign),   32'(m_mis));
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] s,
                       input logic [31:0] t, input logic [31:0] a, input logic h);
    @(negedge clk);
    rst = r; en = e; PCSrc = s; PCTarget = t; ALUResult = a; halt_req = h;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    // Reset and boot
    cycle(1, 0, 2'b00, 0, 0, 0);
    cycle(1, 1, 2'b00, 0, 0, 0);
    check("boot_pc", PC, 32'h0);
    check("boot_valid", 32'(pc_valid), 32'd0);
    cycle(0, 1, 2'b00, 0, 0, 0);
    check("run_valid", 32'(pc_valid), 32'd1);

    // Sequential then branch
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'b00, 0, 0, 0);
    check("seq_pc", PC, 32'd12);
    check("seq_instret", instret, 32'd3);
    cycle(0, 1, 2'b01, 32'h40, 0, 0);
    check("branch_pc", PC, 32'h40);

    // Stall then JALR
    cycle(0, 0, 2'b00, 0, 0, 0);
    cycle(0, 0, 2'b01, 32'h200, 0, 0);
    check("stall_pc", PC, 32'h40);
    cycle(0, 1, 2'b10, 0, 32'h0000_0081, 0);
    check("jalr_pc", PC, 32'h80);

    // Halt wins over branch
    cycle(0, 1, 2'b01, 32'h300, 0, 1);
    check("halt_pc", PC, 32'h80);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_instret", instret, 32'd6);
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'($urandom_range(3)), $urandom, $urandom, 1'($urandom_range(1)));
    cycle(1, 0, 2'b00, 0, 0, 0);
    check("rst_halted", 32'(halted), 32'd0);
    cycle(0, 1, 2'b00, 0, 0, 0);

    // PC wrap
    cycle(0, 1, 2'b01, 32'hFFFF_FFFC, 0, 0);
    cycle(0, 1, 2'b00, 0, 0, 0);
    check("wrap_pc", PC, 32'h0);
    check("wrap_mis", 32'(misalign), 32'd0);

    // instret wrap via preload
    cycle(0, 0, 2'b00, 0, 0, 0);
    @(negedge clk);
    force dut.r_instret = 32'hFFFF_FFFE;
    #1;
    release dut.r_instret;
    m_cnt = 32'hFFFF_FFFE;
    cycle(0, 1, 2'b00, 0, 0, 0);
    cycle(0, 1, 2'b00, 0, 0, 0);
    check("instret_wrap", instret, 32'h0);

    // Misaligned target
    cycle(0, 1, 2'b01, 32'h0000_0102, 0, 0);
    check("mis_pc", PC, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_flag", 32'(misalign), 32'd1);
`else
    check("mis_flag", 32'(misalign), 32'd0);
`endif
    cycle(0, 1, 2'b00, 0, 0, 0);
    check("mis_clear", 32'(misalign), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      cycle(($urandom_range(39) == 0), ($urandom_range(3) != 0), 2'($urandom_range(3)),
            tgt, $urandom, ($urandom_range(29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage that consumes the branch/jump target computed downstream (PC + ImmExt) and the ALU result for JALR.
- Holds the architectural PC register and selects the next PC from PC+4, the branch target or the JALR target.
- Provides fetch-valid qualification, a halt state for ECALL/EBREAK and a retired-instruction counter.
- Sits between control/datapath outputs and the instruction-memory address port of the single-cycle core.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target (optional feature only).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; when 0, PC and counter hold.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = PCTarget, 10 = ALUResult with bit0 cleared, 11 = reserved, treated as PC+4.
- PCTarget  input  XLEN  branch/JAL target from the target adder.
- ALUResult  input  XLEN  JALR target.
- halt_req  input  1  current instruction is ECALL/EBREAK.
- PC  output  XLEN  current PC, registered.
- PCPlus4  output  XLEN  combinational PC+4, modulo 2^XLEN.
- pc_valid  output  1  PC addresses a live instruction.
- halted  output  1  core is in HALT.
- instret  output  32  retired-instruction count, registered.
- misalign  output  1  one-cycle trap pulse (0 when the optional feature is absent).

Behaviour:
- State machine with three states: BOOT, RUN, HALT.
- Reset:
  - Reset to BOOT, PC = RESET_VECTOR.
  - pc_valid = 0, halted = 0, instret = 0, misalign = 0.
  - rst overrides every other input in every state, including mid-HALT.
- BOOT:
  - Lasts exactly one cycle after rst is deasserted, then moves to RUN unconditionally.
  - PC holds at RESET_VECTOR; pc_valid = 0.
- RUN:
  - pc_valid = 1.
  - On a clk edge with en = 1 and halt_req = 0: PC <= selected next PC and instret <= instret + 1.
  - With en = 0: everything holds.
- Halt request:
  - On a clk edge with en = 1 and halt_req = 1: go to HALT, PC holds and instret increments (the halting instruction retires).
  - halt_req wins over any PCSrc value.
- HALT:
  - halted = 1, pc_valid = 0.
  - PC and instret are frozen; all inputs are ignored.
  - Only rst leaves this state.
- Next-PC selection:
  - Latency: PC reflects the selection one cycle after the enabling edge.
  - JALR target = ALUResult & ~1.
- Arithmetic: all additions are modulo 2^XLEN. PC = 32'hFFFF_FFFC with PCSrc = 00 advances to 32'h0000_0000 and raises no flag.
- instret wraps from 32'hFFFF_FFFF to 0.
- Outputs are registered, except PCPlus4 and the combinational next-PC mux feeding the register.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - If the selected next PC has bits[1:0] != 0 on an advancing edge, PC <= TRAP_VECTOR.
  - misalign = 1 for exactly the following cycle.
  - instret still increments.
  - halt_req takes priority over the trap.
- Undefined:
  - Bits[1:0] of the selected next PC are forced to 00.
  - misalign is tied to 0.

Decomposition:
- Shared package pc_pkg holds:
  - PCSrc encodings (PCSRC_PLUS4, PCSRC_TARGET, PCSRC_JALR).
  - State enum (BOOT, RUN, HALT).
  - Default RESET_VECTOR and TRAP_VECTOR constants.
- One natural sub-module, pc_next_mux: the combinational selector that produces the next PC and the misalignment flag from PC, PCPlus4, PCTarget, ALUResult and PCSrc.
- The register, FSM and counter stay in pc_sequencer.

Test Plan:
- Reset and boot: rst high 2 cycles, then low:
  - PC = 0, pc_valid = 0 during the first cycle after release.
  - pc_valid = 1 on the next cycle.
  - instret = 0 throughout.
- Sequential and branch flow:
  - en = 1, PCSrc = 00 for 3 cycles -> PC sequence 0, 4, 8, 12 and instret = 3.
  - Then PCSrc = 01, PCTarget = 32'h40 -> PC = 32'h40 next cycle.
- Stall and JALR:
  - en = 0 for 2 cycles at PC = 32'h40 -> PC and instret hold.
  - Then PCSrc = 10, ALUResult = 32'h0000_0081 -> PC = 32'h80.
- Halt:
  - At PC = 32'h80, halt_req = 1 with PCSrc = 01 -> PC stays 32'h80, halted = 1, pc_valid = 0, instret +1.
  - Further en/PCSrc activity changes nothing.
  - rst -> PC = 0, halted = 0.
- Wrap:
  - Force PC to 32'hFFFF_FFFC via PCTarget, then PCSrc = 00 -> PC = 0, misalign = 0.
  - Preload instret near 32'hFFFF_FFFF and confirm it wraps to 0.
- Misaligned target:
  - PCSrc = 01, PCTarget = 32'h0000_0102.
  - With PC_MISALIGN_TRAP_EN: PC = 32'h100, misalign = 1 for one cycle.
  - Without it: PC = 32'h100, misalign = 0.
